float_unpack: RTL and testbench
===============================

FLOAT_UNPACK -- requirements
Module: float_unpack

Interface
REQ-001 SHALL have parameter EXP, default 8, exponent field width in bits (EXP >= 3).
REQ-002 SHALL have parameter FRAC, default 23, fraction field width in bits (1 <= FRAC < 2**(EXP-1)).
REQ-003 SHALL have ports: clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have ports: resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports: inValid  input  1  inFloat holds a packed float.
REQ-006 SHALL have ports: inReady  output  1  block accepts inFloat this cycle.
REQ-007 SHALL have ports: inFloat  input  1+EXP+FRAC  packed {sign, biased exponent, fraction}.
REQ-008 SHALL have ports: outValid  output  1  unpacked result present.
REQ-009 SHALL have ports: outReady  input  1  consumer takes the result this cycle.
REQ-010 SHALL have ports: outSign  output  1  sign bit.
REQ-011 SHALL have ports: outExp  output  EXP+2  signed, unbiased exponent.
REQ-012 SHALL have ports: outSig  output  FRAC+1  significand, explicit leading bit at MSB.
REQ-013 SHALL have ports: outIsZero, outIsSubnormal, outIsInf, outIsNan  output  1 each  class flags, at most one set.

Function
REQ-014 SHALL transfer input when inValid && inReady, output when outValid && outReady.
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers fields, class, and fraction leading-zero count; stage 2 registers normalized shift and exponent arithmetic.
REQ-016 SHALL present a result on outValid exactly 2 cycles after acceptance when not stalled.
REQ-017 SHALL sustain one transfer per cycle; inReady = !s1Valid || s1 advances; s1 advances when !s2Valid || outReady.
REQ-018 SHALL hold all output registers stable while outValid && !outReady.
REQ-019 SHALL, for normal inputs (biased exponent 1..2**EXP-2), give outExp = biasedExp - (2**(EXP-1)-1) and outSig = {1, fraction}.
REQ-020 SHALL, for subnormal inputs (biased 0, fraction != 0), give outSig = fraction shifted left by lz+1 and outExp = (2 - 2**(EXP-1)) - 1 - lz, where lz = leading zeros of fraction; set outIsSubnormal.
REQ-021 SHALL, for zero inputs, set outIsZero, outExp = 0, outSig = 0, with sign preserved.
REQ-022 SHALL, for biased exponent all ones, give outExp = 2**(EXP-1) and outSig = {0, fraction}; set outIsInf if fraction == 0, else outIsNan.
REQ-023 SHALL compute all exponent arithmetic at EXP+2 signed width without overflow.
REQ-024 SHALL, when a transfer in and out coincide with a full pipeline, accept and deliver in the same cycle with no bubble.

Reset
REQ-025 SHALL, while resetn is low at a clock edge, clear s1Valid, s2Valid, and all output data and flags to 0; inReady = 1 on the first cycle after release.
REQ-026 SHALL discard in-flight items on mid-operation reset, with no output produced for them.

Configuration
REQ-027 SHALL, with FLOAT_UNPACK_SUBNORMAL_EN defined, decode subnormals per REQ-020.
REQ-028 SHALL, without FLOAT_UNPACK_SUBNORMAL_EN, flush subnormals to signed zero per REQ-021 (outIsSubnormal never set) and omit the leading-zero counter and shifter.

Structure
REQ-029 SHALL place exponent bias, min normal/subnormal signed exponent, max signed exponent helpers, and a class enum {ZERO, SUBNORMAL, NORMAL, INF, NAN} in the shared float definition package.
REQ-030 SHALL instantiate one sub-module, CountLeadingZeros (width FRAC, output clog2(FRAC+1) bits), in stage 1.

Verification
REQ-031 SHALL verify: EXP=8 FRAC=23, in 0x3F800000 -> sign 0, exp 0, sig 0x800000, no flags, 2 cycles later.
REQ-032 SHALL verify: in 0x00000001 (macro on) -> exp -149, sig 0x800000, outIsSubnormal; macro off -> outIsZero, sig 0.
REQ-033 SHALL verify: in 0xFF800000 -> sign 1, exp 128, outIsInf; in 0x7FC00000 -> exp 128, sig 0x400000, outIsNan.
REQ-034 SHALL verify: 8 back-to-back inputs with outReady toggling 1,0,0,1 -> all results in order, none lost or duplicated, outputs stable during stall, full throughput when outReady=1.
REQ-035 SHALL verify: resetn low for 1 cycle with 2 items in flight -> outValid 0 next cycle, no stale output, inReady 1.

Source files
------------

// File: rtl/float_unpack_pkg.sv
// -----------------------------------------------------------------------------
// float_unpack_pkg
// Shared float definitions for the unpacker: the operand class enumeration and
// signed-exponent helpers derived from the exponent field width.
// No ports (package).
// -----------------------------------------------------------------------------
package float_unpack_pkg;

  // Operand class decided in stage 1 from the biased exponent and fraction
  typedef enum logic [2:0] {
    ZERO,
    SUBNORMAL,
    NORMAL,
    INF,
    NAN
  } floatClass_e;

  // Exponent bias for an expW-bit exponent field
  function automatic int expBias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  // Unbiased exponent of the smallest normal number
  function automatic int minNormalExp(input int expW);
    return 1 - expBias(expW);
  endfunction

  // Unbiased exponent of the smallest subnormal number
  function automatic int minSubnormalExp(input int expW, input int fracW);
    return minNormalExp(expW) - fracW;
  endfunction

  // Unbiased exponent of the largest normal number
  function automatic int maxNormalExp(input int expW);
    return expBias(expW);
  endfunction

  // Unbiased exponent reported for Inf/NaN (all-ones biased exponent)
  function automatic int maxSpecialExp(input int expW);
    return 1 << (expW - 1);
  endfunction

endpackage

// File: rtl/float_unpack_clz.sv
// -----------------------------------------------------------------------------
// CountLeadingZeros
// Combinational leading-zero counter, scanning from the MSB.
// Ports:
//   value_i  W bits              operand
//   count_o  clog2(W+1) bits     number of zeros above the highest set bit
//                                (W when value_i is zero)
// -----------------------------------------------------------------------------
module CountLeadingZeros #(
  parameter int W = 23
) (
  input  logic [W-1:0]               value_i,
  output logic [$clog2(W+1)-1:0]     count_o
);

  localparam int LZW = $clog2(W + 1);

  logic found;

  // Count zeros until the first one is seen; later bits no longer matter
  always_comb begin
    count_o = '0;
    found   = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (value_i[i]) begin
          found = 1'b1;
        end else begin
          count_o = count_o + LZW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/float_unpack.sv
// -----------------------------------------------------------------------------
// float_unpack
// Two-stage valid/ready pipeline that unpacks a packed {sign, biased exponent,
// fraction} float into sign, signed unbiased exponent, explicit-MSB significand
// and one-hot class flags.
//   Stage 1: registers the fields, the class and (optionally) the fraction
//            leading-zero count.
//   Stage 2: registers the normalising shift and exponent arithmetic; these
//            registers drive the outputs directly.
// Configuration macro: FLOAT_UNPACK_SUBNORMAL_EN
//   defined   -> subnormals are normalised (leading-zero counter + shifter)
//   undefined -> subnormals flush to signed zero
// Ports:
//   clock, resetn (synchronous, active-low)
//   inValid/inReady/inFloat           input handshake and packed operand
//   outValid/outReady                 output handshake
//   outSign, outExp (EXP+2 signed), outSig (FRAC+1)
//   outIsZero, outIsSubnormal, outIsInf, outIsNan
// -----------------------------------------------------------------------------
module float_unpack
  import float_unpack_pkg::*;
#(
  parameter int EXP  = 8,
  parameter int FRAC = 23
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [EXP+FRAC:0]     inFloat,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  outSign,
  output logic signed [EXP+1:0] outExp,
  output logic [FRAC:0]         outSig,
  output logic                  outIsZero,
  output logic                  outIsSubnormal,
  output logic                  outIsInf,
  output logic                  outIsNan
);

  localparam int EW = EXP + 2;

  localparam logic signed [EW-1:0] BIAS_S    = EW'(expBias(EXP));
  localparam logic signed [EW-1:0] SPECIAL_S = EW'(maxSpecialExp(EXP));

  // Input field split
  logic            inSign;
  logic [EXP-1:0]  inBiased;
  logic [FRAC-1:0] inFrac;
  floatClass_e     inClass;

  assign inSign   = inFloat[EXP+FRAC];
  assign inBiased = inFloat[EXP+FRAC-1:FRAC];
  assign inFrac   = inFloat[FRAC-1:0];

  // Stage 1 registers
  logic            s1Valid_q;
  logic            s1Sign_q;
  logic [EXP-1:0]  s1Biased_q;
  logic [FRAC-1:0] s1Frac_q;
  floatClass_e     s1Class_q;

  // Stage 2 (output) registers and their next-state values
  logic                 outValid_q;
  logic                 outSign_q;
  logic signed [EW-1:0] outExp_q,  outExp_d;
  logic [FRAC:0]        outSig_q,  outSig_d;
  logic                 outIsZero_q, outIsZero_d;
  logic                 outIsSub_q,  outIsSub_d;
  logic                 outIsInf_q,  outIsInf_d;
  logic                 outIsNan_q,  outIsNan_d;

  logic s1Advance;

`ifdef FLOAT_UNPACK_SUBNORMAL_EN
  localparam int LZW = $clog2(FRAC + 1);
  // Subnormal value is frac * 2^(minNormal - FRAC); normalising by lz+1 gives this base
  localparam logic signed [EW-1:0] SUB_BASE_S = EW'(minNormalExp(EXP) - 1);

  logic [LZW-1:0] inLz;
  logic [LZW-1:0] s1Lz_q;

  CountLeadingZeros #(.W(FRAC)) u_clz (
    .value_i (inFrac),
    .count_o (inLz)
  );
`endif

  // Stage 1 can hand over whenever the output register is empty or draining
  assign s1Advance = !outValid_q || outReady;
  assign inReady   = !s1Valid_q || s1Advance;

  // Classify the incoming operand; all-ones exponent wins over the zero check
  always_comb begin
    inClass = NORMAL;
    if (&inBiased) begin
      inClass = (inFrac == '0) ? INF : NAN;
    end else if (inBiased == '0) begin
`ifdef FLOAT_UNPACK_SUBNORMAL_EN
      inClass = (inFrac == '0) ? ZERO : SUBNORMAL;
`else
      inClass = ZERO;
`endif
    end
  end

  // Stage 2 datapath: exponent arithmetic is done at EXP+2 signed bits so the
  // deepest subnormal exponent and the special exponent both fit
  always_comb begin
    outExp_d    = '0;
    outSig_d    = '0;
    outIsZero_d = 1'b0;
    outIsSub_d  = 1'b0;
    outIsInf_d  = 1'b0;
    outIsNan_d  = 1'b0;
    case (s1Class_q)
      NORMAL: begin
        outExp_d = $signed({2'b00, s1Biased_q}) - BIAS_S;
        outSig_d = {1'b1, s1Frac_q};
      end
`ifdef FLOAT_UNPACK_SUBNORMAL_EN
      SUBNORMAL: begin
        outExp_d   = SUB_BASE_S - $signed(EW'(s1Lz_q));
        outSig_d   = {s1Frac_q, 1'b0} << s1Lz_q;
        outIsSub_d = 1'b1;
      end
`endif
      INF: begin
        outExp_d   = SPECIAL_S;
        outSig_d   = {1'b0, s1Frac_q};
        outIsInf_d = 1'b1;
      end
      NAN: begin
        outExp_d   = SPECIAL_S;
        outSig_d   = {1'b0, s1Frac_q};
        outIsNan_d = 1'b1;
      end
      default: begin
        outIsZero_d = 1'b1;
      end
    endcase
  end

  // Pipeline registers: stage 1 loads on input handshake, stage 2 loads when
  // stage 1 advances; output data only changes when a valid item moves in
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1Valid_q   <= 1'b0;
      s1Sign_q    <= 1'b0;
      s1Biased_q  <= '0;
      s1Frac_q    <= '0;
      s1Class_q   <= ZERO;
`ifdef FLOAT_UNPACK_SUBNORMAL_EN
      s1Lz_q      <= '0;
`endif
      outValid_q  <= 1'b0;
      outSign_q   <= 1'b0;
      outExp_q    <= '0;
      outSig_q    <= '0;
      outIsZero_q <= 1'b0;
      outIsSub_q  <= 1'b0;
      outIsInf_q  <= 1'b0;
      outIsNan_q  <= 1'b0;
    end else begin
      if (inReady) begin
        s1Valid_q <= inValid;
        if (inValid) begin
          s1Sign_q   <= inSign;
          s1Biased_q <= inBiased;
          s1Frac_q   <= inFrac;
          s1Class_q  <= inClass;
`ifdef FLOAT_UNPACK_SUBNORMAL_EN
          s1Lz_q     <= inLz;
`endif
        end
      end
      if (s1Advance) begin
        outValid_q <= s1Valid_q;
        if (s1Valid_q) begin
          outSign_q   <= s1Sign_q;
          outExp_q    <= outExp_d;
          outSig_q    <= outSig_d;
          outIsZero_q <= outIsZero_d;
          outIsSub_q  <= outIsSub_d;
          outIsInf_q  <= outIsInf_d;
          outIsNan_q  <= outIsNan_d;
        end
      end
    end
  end

  assign outValid       = outValid_q;
  assign outSign        = outSign_q;
  assign outExp         = outExp_q;
  assign outSig         = outSig_q;
  assign outIsZero      = outIsZero_q;
  assign outIsSubnormal = outIsSub_q;
  assign outIsInf       = outIsInf_q;
  assign outIsNan       = outIsNan_q;

endmodule

// File: tb/tb_float_unpack.sv
// -----------------------------------------------------------------------------
// tb_float_unpack
// Self-checking bench for float_unpack at EXP=8, FRAC=23. Honours the
// FLOAT_UNPACK_SUBNORMAL_EN macro in its reference model.
// -----------------------------------------------------------------------------
module tb_float_unpack;

  typedef struct packed {
    logic               sign;
    logic signed [9:0]  expo;
    logic [23:0]        sig;
    logic [3:0]         flags;   // {zero, subnormal, inf, nan}
  } result_t;

  typedef struct packed {
    logic [31:0] in;
    result_t     want;
  } vec_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic inValid = 1'b0;
  logic inReady;
  logic [31:0] inFloat = '0;
  logic outValid;
  logic outReady = 1'b0;
  logic outSign;
  logic signed [9:0] outExp;
  logic [23:0] outSig;
  logic outIsZero, outIsSubnormal, outIsInf, outIsNan;

  int vecCount = 0;
  int missCount = 0;
  bit monEn = 0;
  int readyMode = 0;
  int cyc = 0;
  result_t sb[$];
  vec_t tbl[9];

  always #5 clock = ~clock;

  float_unpack #(.EXP(8), .FRAC(23)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .inValid        (inValid),
    .inReady        (inReady),
    .inFloat        (inFloat),
    .outValid       (outValid),
    .outReady       (outReady),
    .outSign        (outSign),
    .outExp         (outExp),
    .outSig         (outSig),
    .outIsZero      (outIsZero),
    .outIsSubnormal (outIsSubnormal),
    .outIsInf       (outIsInf),
    .outIsNan       (outIsNan)
  );

  // Reference model: value = (-1)^s * sig * 2^(expo-23), written from the
  // float definition using the position of the highest set bit for subnormals
  function automatic result_t modelUnpack(input logic [31:0] f);
    result_t r;
    int be;
    int p;
    logic [22:0] fr;
    r = '0;
    r.sign = f[31];
    be = int'(f[30:23]);
    fr = f[22:0];
    if (be == 255) begin
      r.expo = 10'sd128;
      r.sig = {1'b0, fr};
      r.flags = (fr == 0) ? 4'b0010 : 4'b0001;
    end else if (be == 0) begin
      if (fr == 0) begin
        r.flags = 4'b1000;
      end else begin
`ifdef FLOAT_UNPACK_SUBNORMAL_EN
        p = 0;
        for (int b = 0; b < 23; b++) if (fr[b]) p = b;
        r.expo = 10'(p - 149);
        r.sig = 24'(fr) << (23 - p);
        r.flags = 4'b0100;
`else
        r.flags = 4'b1000;
`endif
      end
    end else begin
      r.expo = 10'(be - 127);
      r.sig = {1'b1, fr};
    end
    return r;
  endfunction

  function automatic logic [31:0] randFloat();
    logic s;
    logic [7:0] e;
    logic [22:0] f;
    int k;
    k = $urandom_range(0, 4);
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    e = 8'd0;
    case (k)
      0: e = 8'($urandom_range(1, 254));
      1: begin
        f = f >> $urandom_range(0, 22);
        if (f == 0) f = 23'd1;
      end
      2: f = '0;
      3: begin e = 8'hFF; f = '0; end
      default: begin e = 8'hFF; if (f == 0) f = 23'd1; end
    endcase
    return {s, e, f};
  endfunction

  function automatic result_t dutNow();
    result_t r;
    r.sign = outSign;
    r.expo = outExp;
    r.sig = outSig;
    r.flags = {outIsZero, outIsSubnormal, outIsInf, outIsNan};
    return r;
  endfunction

  task automatic checkOutput(input string name, input result_t want);
    result_t got;
    got = dutNow();
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got sign=%0b exp=%0d sig=%06h flags=%04b, want sign=%0b exp=%0d sig=%06h flags=%04b",
               name, got.sign, got.expo, got.sig, got.flags, want.sign, want.expo, want.sig, want.flags);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got %0b, want %0b", name, got, want);
    end
  endtask

  task automatic setReady();
    case (readyMode)
      0: outReady = 1'b1;
      1: outReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: outReady = 1'($urandom_range(0, 1));
    endcase
    cyc++;
  endtask

  task automatic stepCycle();
    setReady();
    @(posedge clock);
    #1;
  endtask

  // Present one operand and hold it until it is accepted (bounded)
  task automatic applyStimulus(input logic [31:0] f);
    logic acc;
    acc = 1'b0;
    inFloat = f;
    inValid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      setReady();
      @(negedge clock);
      acc = inReady;
      @(posedge clock);
      #1;
      if (acc) break;
    end
    inValid = 1'b0;
    if (!acc) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL accept-timeout: got inReady=0 for 100 cycles, want 1");
    end
  endtask

  // Single isolated vector: check 2-cycle latency and result
  task automatic applyVector(input vec_t v, input int idx);
    outReady = 1'b1;
    inFloat = v.in;
    inValid = 1'b1;
    @(negedge clock);
    checkBit($sformatf("vec%0d inReady", idx), inReady, 1'b1);
    @(posedge clock);
    #1;
    inValid = 1'b0;
    @(negedge clock);
    checkBit($sformatf("vec%0d early outValid", idx), outValid, 1'b0);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkBit($sformatf("vec%0d outValid", idx), outValid, 1'b1);
    checkOutput($sformatf("vec%0d %08h", idx, v.in), v.want);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    inValid = 1'b0;
    readyMode = 0;
    for (int t = 0; t < 30; t++) begin
      if (sb.size() == 0) break;
      stepCycle();
    end
    vecCount++;
    if (sb.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain: got %0d results outstanding, want 0", sb.size());
    end
  endtask

  // Scoreboard: every valid output must match the oldest outstanding item,
  // including while stalled; ready behaviour follows pipeline occupancy
  always @(negedge clock) begin
    if (monEn) begin
      if (outReady) begin
        checkBit("inReady with outReady", inReady, 1'b1);
      end else if (sb.size() == 2) begin
        checkBit("inReady full stall", inReady, 1'b0);
      end
      if (outValid) begin
        if (sb.size() == 0) begin
          vecCount++;
          missCount++;
          $display("[TB] FAIL spurious output: got outValid=1, want 0 (nothing outstanding)");
        end else begin
          checkOutput("stream", sb[0]);
          if (outReady) void'(sb.pop_front());
        end
      end
      if (inValid && inReady) sb.push_back(modelUnpack(inFloat));
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{32'h3F800000, '{1'b0, 10'sd0,   24'h800000, 4'b0000}};
`ifdef FLOAT_UNPACK_SUBNORMAL_EN
    tbl[1] = '{32'h00000001, '{1'b0, -10'sd149, 24'h800000, 4'b0100}};
    tbl[2] = '{32'h00400000, '{1'b0, -10'sd127, 24'h800000, 4'b0100}};
`else
    tbl[1] = '{32'h00000001, '{1'b0, 10'sd0,   24'h000000, 4'b1000}};
    tbl[2] = '{32'h80400000, '{1'b1, 10'sd0,   24'h000000, 4'b1000}};
`endif
    tbl[3] = '{32'hFF800000, '{1'b1, 10'sd128, 24'h000000, 4'b0010}};
    tbl[4] = '{32'h7FC00000, '{1'b0, 10'sd128, 24'h400000, 4'b0001}};
    tbl[5] = '{32'h80000000, '{1'b1, 10'sd0,   24'h000000, 4'b1000}};
    tbl[6] = '{32'h7F7FFFFF, '{1'b0, 10'sd127, 24'hFFFFFF, 4'b0000}};
    tbl[7] = '{32'h00800000, '{1'b0, -10'sd126, 24'h800000, 4'b0000}};
    tbl[8] = '{32'hC0490FDB, '{1'b1, 10'sd1,   24'hC90FDB, 4'b0000}};

    // Reset state
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    checkBit("reset outValid", outValid, 1'b0);
    checkBit("reset inReady", inReady, 1'b1);
    checkOutput("reset outputs", '0);
    @(posedge clock);
    #1;

    // Directed table
    for (int i = 0; i < 9; i++) applyVector(tbl[i], i);

    // Randomized stream with random back-pressure
    monEn = 1;
    readyMode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) applyStimulus(randFloat());
      else stepCycle();
    end
    drain();

    // Eight back-to-back items with outReady cycling 1,0,0,1
    readyMode = 1;
    cyc = 0;
    for (int i = 0; i < 8; i++) applyStimulus(randFloat());
    drain();

    // Mid-flight reset with two items in the pipeline
    monEn = 0;
    sb.delete();
    outReady = 1'b0;
    inFloat = 32'h3F800000;
    inValid = 1'b1;
    @(posedge clock);
    #1;
    inFloat = 32'hC0000000;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    @(negedge clock);
    checkBit("pre-reset outValid", outValid, 1'b1);
    checkBit("pre-reset inReady", inReady, 1'b0);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    checkBit("post-reset outValid", outValid, 1'b0);
    checkBit("post-reset inReady", inReady, 1'b1);
    checkOutput("post-reset outputs", '0);
    outReady = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clock);
      checkBit($sformatf("post-reset stale %0d", t), outValid, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
